// File: rtl/toggle_receiver_if.sv
// Consumer handshake for toggle_receiver: valid/ready pop port plus the pending count.
// Master is the receiver (produces events), slave is the consumer.
interface toggle_receiver_if #(
  parameter int unsigned CNT_W = 4
);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] pending;

  modport master (output valid, output pending, input ready);
  modport slave  (input valid, input pending, output ready);
endinterface

// File: rtl/toggle_receiver.sv
// Toggle-link receive end: synchronises in_i, turns each level change into a pulse and
// queues it in a saturating pending counter. Optional TOGGLE_RECEIVER_GLITCH_FILTER_EN.
module toggle_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  input  logic clr_ovf_i,
  output logic pulse_o,
  output logic overflow_o,
  toggle_receiver_if.master ev_if
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev_q;
  logic                   evt;
  logic                   pop;
  logic                   pulse_q;
  logic                   overflow_q, overflow_d;
  logic [CNT_W-1:0]       pending_q, pending_d;

  assign s = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_RECEIVER_GLITCH_FILTER_EN
  // flt_q is the last accepted level; a change counts only once s and s_prev_q agree on it.
  logic flt_q, flt_d;

  assign evt   = (s == s_prev_q) && (s != flt_q);
  assign flt_d = evt ? s_prev_q : flt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flt_q <= 1'b0;
    else        flt_q <= flt_d;
  end
`else
  assign evt = s ^ s_prev_q;
`endif

  assign pop           = ev_if.valid && ev_if.ready;
  assign ev_if.valid   = (pending_q != '0);
  assign ev_if.pending = pending_q;
  assign pulse_o       = pulse_q;
  assign overflow_o    = overflow_q;

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (clr_ovf_i) overflow_d = 1'b0;
    unique case ({evt, pop})
      2'b10: begin
        if (pending_q != '1) pending_d  = pending_q + CNT_W'(1);
        else                 overflow_d = 1'b1;
      end
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      pulse_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_i};
      s_prev_q   <= s;
      pulse_q    <= evt;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_toggle_receiver.sv
// Directed self-checking bench for toggle_receiver (default depth 2, CNT_W 4).
// Build with TOGGLE_RECEIVER_GLITCH_FILTER_EN to exercise the filtered variant.
module tb_toggle_receiver;

`ifdef TOGGLE_RECEIVER_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tin = 1'b0;
  logic clr_ovf = 1'b0;
  logic pulse, overflow;

  int asserts = 0;
  int fails   = 0;
  int pulses  = 0;
  int peak    = 0;

  toggle_receiver_if #(.CNT_W(4)) ev ();

  toggle_receiver #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (tin),
    .clr_ovf_i  (clr_ovf),
    .pulse_o    (pulse),
    .overflow_o (overflow),
    .ev_if      (ev)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic in_val);
    @(negedge clk);
    rst_n    = 1'b0;
    tin      = in_val;
    ev.ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transition, then checks pulse is high exactly LAT edges after sampling.
  task automatic send();
    logic exp;
    @(negedge clk);
    tin = ~tin;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      exp = (k == LAT - 1);
      if (pulse) pulses++;
      if (int'(ev.pending) > peak) peak = int'(ev.pending);
      asserts++;
      if (pulse !== exp) begin
        fails++;
        $display("FAIL pulse_timing k=%0d got %b want %b", k, pulse, exp);
      end
    end
  endtask

  task automatic test_reset();
    ev.ready = 1'b0;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({pulse, ev.valid, ev.pending, overflow} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 0", {pulse, ev.valid, ev.pending, overflow});
    end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    repeat (5) send();
    asserts++;
    if (ev.pending !== 4'd5) begin fails++; $display("FAIL basic_pending got %0d want 5", ev.pending); end
    asserts++;
    if (ev.valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", ev.valid); end
    asserts++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow got %b want 0", overflow); end
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    ev.ready = 1'b1;
    peak = 0;
    pulses = 0;
    repeat (8) send();
    asserts++;
    if (peak != 1) begin fails++; $display("FAIL stream_peak got %0d want 1", peak); end
    asserts++;
    if (ev.pending !== 4'd0) begin fails++; $display("FAIL stream_pending got %0d want 0", ev.pending); end
    asserts++;
    if (pulses != 8) begin fails++; $display("FAIL stream_pulses got %0d want 8", pulses); end
    ev.ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    repeat (15) send();
    asserts++;
    if (ev.pending !== 4'd15 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_fill got pending=%0d ovf=%b want 15/0", ev.pending, overflow);
    end
    for (int i = 0; i < 2; i++) begin
      send();
      asserts++;
      if (ev.pending !== 4'd15 || overflow !== 1'b1) begin
        fails++; $display("FAIL ovf_sat%0d got pending=%0d ovf=%b want 15/1", i, ev.pending, overflow);
      end
    end
    @(negedge clk);
    clr_ovf  = 1'b1;
    ev.ready = 1'b1;
    @(negedge clk);
    asserts++;
    if (ev.pending !== 4'd14 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clear got pending=%0d ovf=%b want 14/0", ev.pending, overflow);
    end
    repeat (14) @(negedge clk);
    asserts++;
    if (ev.pending !== 4'd0 || ev.valid !== 1'b0) begin
      fails++; $display("FAIL ovf_drain got pending=%0d valid=%b want 0/0", ev.pending, ev.valid);
    end
    clr_ovf  = 1'b0;
    ev.ready = 1'b0;
  endtask

  task automatic test_max_corner();
    do_reset(1'b0);
    repeat (15) send();
    // Pop lands on the same edge as the event: count holds, no loss.
    @(negedge clk);
    tin = ~tin;
    repeat (LAT - 1) @(negedge clk);
    ev.ready = 1'b1;
    @(negedge clk);
    ev.ready = 1'b0;
    asserts++;
    if (ev.pending !== 4'd15 || overflow !== 1'b0) begin
      fails++; $display("FAIL evt_pop_max got pending=%0d ovf=%b want 15/0", ev.pending, overflow);
    end
    repeat (2) @(negedge clk);
    tin = ~tin;
    repeat (LAT - 1) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    asserts++;
    if (overflow !== 1'b1 || ev.pending !== 4'd15) begin
      fails++; $display("FAIL set_vs_clear got ovf=%b pending=%0d want 1/15", overflow, ev.pending);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    asserts++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL clr_only got %b want 0", overflow); end
  endtask

  task automatic test_reset_in_high();
    int cnt;
    do_reset(1'b1);
    cnt = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (pulse) cnt++;
    end
    asserts++;
    if (cnt != 1) begin fails++; $display("FAIL inhigh_pulses got %0d want 1", cnt); end
    asserts++;
    if (ev.pending !== 4'd1) begin fails++; $display("FAIL inhigh_pending got %0d want 1", ev.pending); end
    send();
    send();
    asserts++;
    if (ev.pending !== 4'd3) begin fails++; $display("FAIL pre_reset_pending got %0d want 3", ev.pending); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({pulse, ev.valid, ev.pending, overflow} !== 7'b0) begin
      fails++; $display("FAIL async_reset got %b want 0", {pulse, ev.valid, ev.pending, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef TOGGLE_RECEIVER_GLITCH_FILTER_EN
  task automatic test_glitch();
    int cnt;
    do_reset(1'b0);
    @(negedge clk);
    tin = 1'b1;
    @(negedge clk);
    tin = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (pulse) cnt++;
    end
    asserts++;
    if (cnt != 0 || ev.pending !== 4'd0) begin
      fails++; $display("FAIL glitch got pulses=%0d pending=%0d want 0/0", cnt, ev.pending);
    end
    send();
    asserts++;
    if (ev.pending !== 4'd1) begin fails++; $display("FAIL filt_accept got %0d want 1", ev.pending); end
  endtask
`endif

  initial begin
    ev.ready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_overflow();
    test_max_corner();
    test_reset_in_high();
`ifdef TOGGLE_RECEIVER_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
